// File: rtl/sw_cond_if.sv
// Switch conditioner bus: raw pins and clear mask in, debounced word and
// per-bit edge/event status out.
interface sw_cond_if #(
    parameter int unsigned NUM_SW = 17
);
    logic [NUM_SW-1:0] sw_pin_i;
    logic [NUM_SW-1:0] event_clr_i;
    logic [31:0]       io_sw_o;
    logic [NUM_SW-1:0] rise_o;
    logic [NUM_SW-1:0] fall_o;
    logic [NUM_SW-1:0] event_o;
    logic              busy_o;

    // Conditioner side
    modport slave (
        input  sw_pin_i,
        input  event_clr_i,
        output io_sw_o,
        output rise_o,
        output fall_o,
        output event_o,
        output busy_o
    );

    // Board / consumer side
    modport master (
        output sw_pin_i,
        output event_clr_i,
        input  io_sw_o,
        input  rise_o,
        input  fall_o,
        input  event_o,
        input  busy_o
    );
endinterface

// File: rtl/sw_cond.sv
// Switch/key conditioner: per-bit 2-flop synchronizer, counter-based debounce,
// registered rise/fall pulses, sticky write-one-to-clear event flags and a
// busy indication while any bit is mid-count.
module sw_cond #(
    parameter int unsigned NUM_SW   = 17,
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    sw_cond_if.slave    sw_bus
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_stable;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;
    logic [NUM_SW-1:0] r_event;
    logic              r_busy;
    logic [CntW-1:0]   r_cnt [NUM_SW];

    logic [CntW-1:0]   w_cnt_d [NUM_SW];
    logic [NUM_SW-1:0] w_accept;
    logic [NUM_SW-1:0] w_cnt_nz;
    logic [NUM_SW-1:0] w_stable_d;
    logic [31:0]       w_io_sw;

    // Per-bit debounce decision: count while sync2 disagrees with the stable
    // level, accept on the DEBOUNCE-th consecutive disagreeing cycle. Any
    // agreeing cycle drops the count back to zero, so glitches never add up.
    always_comb begin
        w_accept = '0;
        w_cnt_nz = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_cnt_d[i]  = '0;
            w_cnt_nz[i] = (r_cnt[i] != '0);
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CntMax) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + CntW'(1);
                end
            end
        end
        w_stable_d = r_stable ^ w_accept;
    end

    // Synchronizer, debounce state and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_event  <= '0;
            r_busy   <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= sw_bus.sw_pin_i;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_d;
            // Pulses line up with the cycle io_sw_o first shows the new level.
            r_rise   <= w_accept & r_sync2;
            r_fall   <= w_accept & ~r_sync2;
            // Set from the visible pulses so a clear in the pulse cycle loses.
            r_event  <= (r_event & ~sw_bus.event_clr_i) | r_rise | r_fall;
            r_busy   <= |w_cnt_nz;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    // Debounced word, zero-extended to the full 32-bit core input.
    always_comb begin
        w_io_sw               = '0;
        w_io_sw[NUM_SW-1:0]   = r_stable;
    end

    assign sw_bus.io_sw_o = w_io_sw;
    assign sw_bus.rise_o  = r_rise;
    assign sw_bus.fall_o  = r_fall;
    assign sw_bus.event_o = r_event;
    assign sw_bus.busy_o  = r_busy;

    a_rise_fall_excl: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_rise & r_fall) == '0);

endmodule
